addr8s_sum_accum: RTL and testbench

ADDR8S_SUM_ACCUM -- requirements
Module: addr8s_sum_accum

---
 rtl/addr8s_sum_accum.sv | 111 +++++++++++
 tb/tb_addr8s_sum_accum.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr8s_sum_accum.sv
// Accumulates NSAMP signed 9-bit adder sums into a 16-bit frame total, with valid/ready on both
// sides. Define ADDR8S_ACC_SAT_EN to clamp the total at the 16-bit limits and report ovf.
module addr8s_sum_accum #(
  parameter int unsigned NSAMP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  sum_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] acc_out,
  output logic        ovf
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc  = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;
  localparam logic [7:0] NSampC = 8'(NSAMP);

  logic [1:0]  state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        xfer;
  logic [15:0] base, sum_ext, add_res;
  logic [7:0]  cnt_inc;

  assign in_ready  = (state_q != StOut);
  assign out_valid = (state_q == StOut);
  assign acc_out   = acc_q;
  assign xfer      = in_valid & in_ready;
  assign sum_ext   = {{7{sum_in[8]}}, sum_in};
  // The first sample of a frame starts from zero rather than the previous total.
  assign base      = (state_q == StIdle) ? 16'd0 : acc_q;
  assign cnt_inc   = (state_q == StIdle) ? 8'd1 : cnt_q + 8'd1;

`ifdef ADDR8S_ACC_SAT_EN
  logic [16:0] add_wide;
  logic        add_ovf;
  logic        ovf_q, ovf_d;

  assign add_wide = {base[15], base} + {sum_ext[15], sum_ext};
  assign add_ovf  = add_wide[16] ^ add_wide[15];
  assign add_res  = !add_ovf ? add_wide[15:0] : (add_wide[16] ? 16'h8000 : 16'h7fff);
  assign ovf      = ovf_q;
`else
  assign add_res  = base + sum_ext;
  assign ovf      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef ADDR8S_ACC_SAT_EN
    ovf_d   = ovf_q;
`endif
    if (clr) begin
      state_d = StIdle;
      acc_d   = 16'd0;
      cnt_d   = 8'd0;
`ifdef ADDR8S_ACC_SAT_EN
      ovf_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle, StAcc: begin
          if (xfer) begin
            acc_d   = add_res;
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == NSampC) ? StOut : StAcc;
`ifdef ADDR8S_ACC_SAT_EN
            ovf_d   = ((state_q == StIdle) ? 1'b0 : ovf_q) | add_ovf;
`endif
          end
        end
        StOut: begin
          if (out_ready) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= 16'd0;
      cnt_q   <= 8'd0;
`ifdef ADDR8S_ACC_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef ADDR8S_ACC_SAT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_addr8s_sum_accum.sv
// Bench for addr8s_sum_accum: three instances (NSAMP 4, 255, 1) on shared stimulus, checked
// against a frame-level arithmetic model.
module tb_addr8s_sum_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [8:0]  sum_in = 9'd0;
  logic        out_ready = 1'b0;

  logic        rdy4, ov4, ovf4, rdy255, ov255, ovf255, rdy1, ov1, ovf1;
  logic [15:0] acc4, acc255, acc1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addr8s_sum_accum #(.NSAMP(4)) u4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy4),
    .sum_in(sum_in), .out_valid(ov4), .out_ready(out_ready), .acc_out(acc4), .ovf(ovf4)
  );
  addr8s_sum_accum #(.NSAMP(255)) u255 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy255),
    .sum_in(sum_in), .out_valid(ov255), .out_ready(out_ready), .acc_out(acc255), .ovf(ovf255)
  );
  addr8s_sum_accum #(.NSAMP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
    .sum_in(sum_in), .out_valid(ov1), .out_ready(out_ready), .acc_out(acc1), .ovf(ovf1)
  );

  // Frame total from plain integer arithmetic; truncation to 16 bits gives the wrapping case.
  function automatic int model_frame(input int q[$], output bit ov);
    int t;
    t  = 0;
    ov = 1'b0;
    foreach (q[i]) begin
      t += q[i];
`ifdef ADDR8S_ACC_SAT_EN
      if (t > 32767) begin
        t = 32767; ov = 1'b1;
      end else if (t < -32768) begin
        t = -32768; ov = 1'b1;
      end
`endif
    end
    return t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++;
    if (ov4 !== 1'b0 || acc4 !== 16'd0 || ovf4 !== 1'b0 || rdy4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_during: ov=%b acc=%h ovf=%b rdy=%b want 0 0000 0 1",
               ov4, acc4, ovf4, rdy4);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (ov4 !== 1'b0 || acc4 !== 16'd0 || ovf4 !== 1'b0 || rdy4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_after: ov=%b acc=%h ovf=%b rdy=%b want 0 0000 0 1",
               ov4, acc4, ovf4, rdy4);
    end
  endtask

  task automatic test_basic_frame;
    int s[4] = '{100, -50, 255, -256};
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sum_in = 9'(s[i]);
      tick();
      if (i == 2) begin
        checks++;
        if (ov4 !== 1'b0) begin
          errors++;
          $display("FAIL basic_early_valid: out_valid=%b want 0", ov4);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (ov4 !== 1'b1 || acc4 !== 16'h0031 || ovf4 !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: ov=%b acc=%h ovf=%b want 1 0031 0", ov4, acc4, ovf4);
    end
    tick();
    checks++;
    if (ov4 !== 1'b0 || rdy4 !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: ov=%b rdy=%b want 0 1", ov4, rdy4);
    end
  endtask

  task automatic test_saturation;
    logic [15:0] want;
    logic        want_ovf;
`ifdef ADDR8S_ACC_SAT_EN
    want = 16'h7fff; want_ovf = 1'b1;
`else
    want = 16'hfe01; want_ovf = 1'b0;
`endif
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sum_in    = 9'd255;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (i == 253) begin
        checks++;
        if (ov255 !== 1'b0) begin
          errors++;
          $display("FAIL sat_early_valid: out_valid=%b want 0", ov255);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (ov255 !== 1'b1 || acc255 !== want || ovf255 !== want_ovf) begin
      errors++;
      $display("FAIL sat_result: ov=%b acc=%h ovf=%b want 1 %h %b",
               ov255, acc255, ovf255, want, want_ovf);
    end
  endtask

  task automatic test_backpressure;
    int  q[$];
    int  t;
    bit  m_ovf;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q.push_back(int'($urandom_range(0, 511)) - 256);
      sum_in = 9'(q[i]);
      tick();
    end
    t = model_frame(q, m_ovf);
    for (int i = 0; i < 5; i++) begin
      sum_in = 9'($urandom_range(0, 511));
      tick();
      checks++;
      if (ov4 !== 1'b1 || acc4 !== 16'(t) || ovf4 !== m_ovf || rdy4 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: ov=%b acc=%h ovf=%b rdy=%b want 1 %h %b 0",
                 i, ov4, acc4, ovf4, rdy4, 16'(t), m_ovf);
      end
    end
    // in_valid stays high across the release edge; that sample must not be taken.
    sum_in    = 9'd100;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (ov4 !== 1'b0 || rdy4 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: ov=%b rdy=%b want 0 1", ov4, rdy4);
    end
    q.delete();
    for (int i = 0; i < 4; i++) begin
      q.push_back(i + 3);
      sum_in = 9'(i + 3);
      tick();
    end
    in_valid = 1'b0;
    t = model_frame(q, m_ovf);
    checks++;
    if (ov4 !== 1'b1 || acc4 !== 16'(t)) begin
      errors++;
      $display("FAIL bp_next_frame: ov=%b acc=%h want 1 %h", ov4, acc4, 16'(t));
    end
  endtask

  task automatic test_clear;
    int s[6] = '{10, 20, 1, 2, 3, 4};
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sum_in = 9'(s[i]);
      tick();
    end
    clr    = 1'b1;
    sum_in = 9'd99;
    tick();
    clr = 1'b0;
    checks++;
    if (ov4 !== 1'b0 || acc4 !== 16'd0 || rdy4 !== 1'b1) begin
      errors++;
      $display("FAIL clr_mid: ov=%b acc=%h rdy=%b want 0 0000 1", ov4, acc4, rdy4);
    end
    for (int i = 2; i < 6; i++) begin
      sum_in = 9'(s[i]);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (ov4 !== 1'b1 || acc4 !== 16'd10) begin
      errors++;
      $display("FAIL clr_frame: ov=%b acc=%h want 1 000a", ov4, acc4);
    end
    clr       = 1'b1;
    out_ready = 1'b1;
    tick();
    clr       = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (ov4 !== 1'b0 || acc4 !== 16'd0) begin
      errors++;
      $display("FAIL clr_in_out: ov=%b acc=%h want 0 0000", ov4, acc4);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sum_in    = 9'd50;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov4 !== 1'b0 || acc4 !== 16'd0 || ovf4 !== 1'b0 || rdy4 !== 1'b1) begin
      errors++;
      $display("FAIL arst_mid: ov=%b acc=%h ovf=%b rdy=%b want 0 0000 0 1",
               ov4, acc4, ovf4, rdy4);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov4 !== 1'b0 || acc4 !== 16'd0 || rdy4 !== 1'b1) begin
      errors++;
      $display("FAIL arst_out: ov=%b acc=%h rdy=%b want 0 0000 1", ov4, acc4, rdy4);
    end
    rst_n  = 1'b1;
    sum_in = 9'h1ff;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    checks++;
    if (ov4 !== 1'b1 || acc4 !== 16'hfffc) begin
      errors++;
      $display("FAIL arst_next_frame: ov=%b acc=%h want 1 fffc", ov4, acc4);
    end
  endtask

  task automatic test_gapped_nsamp1;
    int          s[2] = '{-256, 7};
    logic [15:0] want[2] = '{16'hff00, 16'h0007};
    do_reset();
    out_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      in_valid = 1'b1;
      sum_in   = 9'(s[f]);
      tick();
      in_valid = 1'b0;
      checks++;
      if (ov1 !== 1'b1 || acc1 !== want[f]) begin
        errors++;
        $display("FAIL n1_frame%0d: ov=%b acc=%h want 1 %h", f, ov1, acc1, want[f]);
      end
      tick();
      checks++;
      if (ov1 !== 1'b0 || rdy1 !== 1'b1) begin
        errors++;
        $display("FAIL n1_gap%0d: ov=%b rdy=%b want 0 1", f, ov1, rdy1);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    int          q[$];
    int          t;
    bit          m_ovf;
    logic [15:0] held;
    do_reset();
    for (int f = 0; f < 20; f++) begin
      q.delete();
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          sum_in   = 9'($urandom_range(0, 511));
          tick();
        end
        q.push_back(int'($urandom_range(0, 511)) - 256);
        in_valid = 1'b1;
        sum_in   = 9'(q[k]);
        checks++;
        if (rdy4 !== 1'b1 || ov4 !== 1'b0) begin
          errors++;
          $display("FAIL rnd_accept f%0d k%0d: rdy=%b ov=%b want 1 0", f, k, rdy4, ov4);
        end
        tick();
      end
      in_valid = 1'b0;
      t = model_frame(q, m_ovf);
      checks++;
      if (ov4 !== 1'b1 || acc4 !== 16'(t) || ovf4 !== m_ovf) begin
        errors++;
        $display("FAIL rnd_frame f%0d: ov=%b acc=%h ovf=%b want 1 %h %b",
                 f, ov4, acc4, ovf4, 16'(t), m_ovf);
      end
      held = 16'(t);
      repeat ($urandom_range(0, 3)) begin
        in_valid = $urandom_range(0, 1) == 1;
        tick();
        checks++;
        if (ov4 !== 1'b1 || acc4 !== held) begin
          errors++;
          $display("FAIL rnd_hold f%0d: ov=%b acc=%h want 1 %h", f, ov4, acc4, held);
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_saturation();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_gapped_nsamp1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
